vw_operand_ext: RTL and testbench

Parametrised, pipelined operand sign/zero-extension stage feeding the PE array.
- Takes NUM_OPS packed operands, each with its own element width (vsew scaled by a per-operand widening code) and its own signed/unsigned select.
- Produces XLEN-bit extended operands behind a valid/ready handshake with a skid buffer.
- Flags illegal width combinations instead of halting simulation.
- Sits between the operand fetch/broadcast logic and the PE multipliers/adders.

---
 rtl/vw_ext_pkg.sv | 12 +
 rtl/vw_ext_lane.sv | 33 +++
 rtl/vw_operand_ext.sv | 117 +++++++++++
 tb/tb_vw_operand_ext.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vw_ext_pkg.sv
// Shared types and helpers for the operand sign/zero-extension stage.
package vw_ext_pkg;

  typedef enum logic [1:0] {SEW8, SEW16, SEW32, SEW_RSVD} sew_e;
  typedef enum logic [1:0] {W1X, W2X, W4X, W_RSVD} widen_e;

  // Effective element width in bits; reserved codes yield oversized widths, callers flag them.
  function automatic int unsigned eff_width(sew_e sew, widen_e widen);
    return 32'd8 << (32'(sew) + 32'(widen));
  endfunction

endpackage

// File: rtl/vw_ext_lane.sv
// One combinational extension lane: sign/zero-extends the low W bits of an operand to XLEN.
module vw_ext_lane
  import vw_ext_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  sew_e            sew,
  input  widen_e          widen,
  input  logic            signed_en,
  output logic [XLEN-1:0] ext,
  output logic            illegal
);

  int unsigned width;
  logic        sign;

  always_comb begin
    width   = eff_width(sew, widen);
    illegal = (sew == SEW_RSVD) || (widen == W_RSVD) || (width > XLEN);
    sign    = 1'b0;
    ext     = '0;
    for (int unsigned b = 0; b < XLEN; b++) begin
      if (b == width - 1) sign = data[b];
    end
    if (!illegal) begin
      for (int unsigned b = 0; b < XLEN; b++) begin
        ext[b] = (b < width) ? data[b] : (signed_en & sign);
      end
    end
  end

endmodule

// File: rtl/vw_operand_ext.sv
// Pipelined operand extension stage: NUM_OPS extension lanes feeding a main register
// backed by a one-entry skid buffer, so in_ready is driven purely from state.
module vw_operand_ext
  import vw_ext_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_OPS = 3,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_OPS*XLEN-1:0] in_data,
  input  logic [1:0]              in_vsew,
  input  logic [NUM_OPS*2-1:0]    in_widen,
  input  logic [NUM_OPS-1:0]      in_signed,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_OPS*XLEN-1:0] out_data,
  output logic [NUM_OPS-1:0]      out_illegal,
  output logic [TAG_W-1:0]        out_tag
);

  logic [NUM_OPS*XLEN-1:0] ext_data;
  logic [NUM_OPS-1:0]      ext_ill;

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_lane
    vw_ext_lane #(
      .XLEN(XLEN)
    ) u_lane (
      .data     (in_data[i*XLEN +: XLEN]),
      .sew      (sew_e'(in_vsew)),
      .widen    (widen_e'(in_widen[2*i +: 2])),
      .signed_en(in_signed[i]),
      .ext      (ext_data[i*XLEN +: XLEN]),
      .illegal  (ext_ill[i])
    );
  end

  logic                    main_valid_q, main_valid_d;
  logic [NUM_OPS*XLEN-1:0] main_data_q, main_data_d;
  logic [NUM_OPS-1:0]      main_ill_q, main_ill_d;
  logic [TAG_W-1:0]        main_tag_q, main_tag_d;
  logic                    skid_valid_q, skid_valid_d;
  logic [NUM_OPS*XLEN-1:0] skid_data_q, skid_data_d;
  logic [NUM_OPS-1:0]      skid_ill_q, skid_ill_d;
  logic [TAG_W-1:0]        skid_tag_q, skid_tag_d;

  logic accept, xfer;

  assign in_ready    = !skid_valid_q;
  assign accept      = in_valid && in_ready;
  assign xfer        = main_valid_q && out_ready;
  assign out_valid   = main_valid_q;
  assign out_data    = main_data_q;
  assign out_illegal = main_ill_q;
  assign out_tag     = main_tag_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ill_d   = main_ill_q;
    main_tag_d   = main_tag_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ill_d   = skid_ill_q;
    skid_tag_d   = skid_tag_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (xfer && skid_valid_q) begin
      // Skid full implies in_ready low, so no new beat competes here.
      main_data_d  = skid_data_q;
      main_ill_d   = skid_ill_q;
      main_tag_d   = skid_tag_q;
      skid_valid_d = 1'b0;
    end else if (accept && (xfer || !main_valid_q)) begin
      main_valid_d = 1'b1;
      main_data_d  = ext_data;
      main_ill_d   = ext_ill;
      main_tag_d   = in_tag;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = ext_data;
      skid_ill_d   = ext_ill;
      skid_tag_d   = in_tag;
    end else if (xfer) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ill_q   <= '0;
      main_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ill_q   <= '0;
      skid_tag_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ill_q   <= main_ill_d;
      main_tag_q   <= main_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ill_q   <= skid_ill_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

endmodule

// File: tb/tb_vw_operand_ext.sv
// Directed bench for vw_operand_ext: vector table for lane extension, hand sequences for
// backpressure, flush and asynchronous reset.
module tb_vw_operand_ext;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NUM_OPS = 3;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned DW      = NUM_OPS * XLEN;

  logic            clk = 1'b0;
  logic            n_reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [1:0]      in_vsew;
  logic [5:0]      in_widen;
  logic [2:0]      in_signed;
  logic [3:0]      in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [2:0]      out_illegal;
  logic [3:0]      out_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vw_operand_ext #(
    .XLEN   (XLEN),
    .NUM_OPS(NUM_OPS),
    .TAG_W  (TAG_W)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_vsew    (in_vsew),
    .in_widen   (in_widen),
    .in_signed  (in_signed),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_illegal(out_illegal),
    .out_tag    (out_tag)
  );

  typedef struct {
    logic [1:0]    vsew;
    logic [5:0]    widen;
    logic [2:0]    sgn;
    logic [DW-1:0] data;
    logic [3:0]    tag;
    logic [DW-1:0] exp_data;
    logic [2:0]    exp_ill;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] sew, input logic [5:0] wid,
                       input logic [2:0] sg, input logic [DW-1:0] d, input logic [3:0] t);
    in_valid  = v;
    in_vsew   = sew;
    in_widen  = wid;
    in_signed = sg;
    in_data   = d;
    in_tag    = t;
  endtask

  // Pass-through beat: 32-bit elements, no widening, so expected output equals input.
  function automatic logic [DW-1:0] bdata(input int k);
    return {32'hC000_0000 + 32'(k), 32'hB000_0000 + 32'(k), 32'hA000_0000 + 32'(k)};
  endfunction

  task automatic beat(input int k);
    drive(1'b1, 2'd2, 6'd0, 3'b111, bdata(k), 4'(k));
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 6'd0, 3'b000, '0, 4'd0);
  endtask

  initial begin
    vecs[0] = '{2'd0, 6'b00_00_00, 3'b011,
                {32'hAB12_3480, 32'h0000_007F, 32'h0000_00F3}, 4'h1,
                {32'h0000_0080, 32'h0000_007F, 32'hFFFF_FFF3}, 3'b000};
    vecs[1] = '{2'd0, 6'b00_10_01, 3'b011,
                {32'h0000_FF80, 32'h8000_0000, 32'h0000_8001}, 4'h2,
                {32'h0000_0080, 32'h8000_0000, 32'hFFFF_8001}, 3'b000};
    vecs[2] = '{2'd1, 6'b10_01_00, 3'b111,
                {32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_8765}, 4'h3,
                {32'h0000_0000, 32'hDEAD_BEEF, 32'hFFFF_8765}, 3'b100};
    vecs[3] = '{2'd3, 6'b00_00_00, 3'b111,
                {32'h1111_1111, 32'h2222_2222, 32'h3333_3333}, 4'h4,
                {DW{1'b0}}, 3'b111};
    vecs[4] = '{2'd2, 6'b01_11_00, 3'b111,
                {32'h5555_5555, 32'h6666_6666, 32'hCAFE_F00D}, 4'h5,
                {32'h0000_0000, 32'h0000_0000, 32'hCAFE_F00D}, 3'b110};
    vecs[5] = '{2'd1, 6'b00_00_00, 3'b110,
                {32'h0000_8000, 32'h0001_7FFF, 32'hFFFF_7FFF}, 4'h6,
                {32'hFFFF_8000, 32'h0000_7FFF, 32'h0000_7FFF}, 3'b000};

    n_reset   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    idle();
    #12;
    chk("reset out_valid", DW'(out_valid), DW'(0));
    chk("reset out_data", out_data, DW'(0));
    chk("reset out_illegal", DW'(out_illegal), DW'(0));
    chk("reset out_tag", DW'(out_tag), DW'(0));
    chk("reset in_ready", DW'(in_ready), DW'(1));
    @(negedge clk);
    n_reset = 1'b1;

    // Table vectors streamed back-to-back with out_ready high: one result per cycle.
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].vsew, vecs[i].widen, vecs[i].sgn, vecs[i].data, vecs[i].tag);
      @(negedge clk);
      chk($sformatf("vec%0d out_valid", i), DW'(out_valid), DW'(1));
      chk($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_data);
      chk($sformatf("vec%0d out_illegal", i), DW'(out_illegal), DW'(vecs[i].exp_ill));
      chk($sformatf("vec%0d out_tag", i), DW'(out_tag), DW'(vecs[i].tag));
    end
    idle();
    @(negedge clk);
    chk("drain out_valid", DW'(out_valid), DW'(0));

    // Backpressure: beat1 in main, beat2 in skid, beat3 stalls until release.
    out_ready = 1'b0;
    beat(1);
    @(negedge clk);
    chk("bp1 in_ready", DW'(in_ready), DW'(1));
    chk("bp1 out_tag", DW'(out_tag), DW'(1));
    beat(2);
    @(negedge clk);
    chk("bp2 in_ready", DW'(in_ready), DW'(0));
    chk("bp2 out_tag", DW'(out_tag), DW'(1));
    beat(3);
    @(negedge clk);
    chk("bp3 in_ready", DW'(in_ready), DW'(0));
    chk("bp3 hold data", out_data, bdata(1));
    chk("bp3 hold tag", DW'(out_tag), DW'(1));
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp4 out_tag", DW'(out_tag), DW'(2));
    chk("bp4 out_data", out_data, bdata(2));
    chk("bp4 in_ready", DW'(in_ready), DW'(1));
    @(negedge clk);
    chk("bp5 out_tag", DW'(out_tag), DW'(3));
    chk("bp5 out_data", out_data, bdata(3));
    beat(4);
    @(negedge clk);
    chk("bp6 out_valid", DW'(out_valid), DW'(1));
    chk("bp6 out_tag", DW'(out_tag), DW'(4));
    chk("bp6 out_data", out_data, bdata(4));
    idle();
    @(negedge clk);
    chk("bp7 out_valid", DW'(out_valid), DW'(0));

    // Flush with both entries full; the beat offered alongside flush is dropped.
    out_ready = 1'b0;
    beat(5);
    @(negedge clk);
    beat(6);
    @(negedge clk);
    chk("fl full in_ready", DW'(in_ready), DW'(0));
    flush = 1'b1;
    beat(7);
    @(negedge clk);
    chk("fl out_valid", DW'(out_valid), DW'(0));
    chk("fl in_ready", DW'(in_ready), DW'(1));
    flush     = 1'b0;
    out_ready = 1'b1;
    idle();
    @(negedge clk);
    chk("fl after out_valid", DW'(out_valid), DW'(0));
    // Flush beats accept even when the stage is empty and ready.
    flush = 1'b1;
    beat(8);
    @(negedge clk);
    chk("fl prio out_valid", DW'(out_valid), DW'(0));
    flush = 1'b0;
    idle();
    @(negedge clk);
    chk("fl prio after", DW'(out_valid), DW'(0));

    // Asynchronous reset mid-cycle with main and skid both occupied.
    beat(9);
    @(negedge clk);
    chk("ar out_tag", DW'(out_tag), DW'(9));
    out_ready = 1'b0;
    beat(10);
    @(negedge clk);
    chk("ar full in_ready", DW'(in_ready), DW'(0));
    idle();
    #2;
    n_reset = 1'b0;
    #1;
    chk("ar out_valid", DW'(out_valid), DW'(0));
    chk("ar in_ready", DW'(in_ready), DW'(1));
    chk("ar out_tag zero", DW'(out_tag), DW'(0));
    @(negedge clk);
    n_reset   = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    beat(11);
    @(negedge clk);
    chk("ar first out_valid", DW'(out_valid), DW'(1));
    chk("ar first out_tag", DW'(out_tag), DW'(11));
    chk("ar first out_data", out_data, bdata(11));
    idle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
